// File: rtl/traffic_phase_sequencer.sv
// traffic_phase_sequencer: timed eight-phase signal sequencer with a pedestrian request latch.
// The registered 3-bit phase code feeds the colour decoder.
// Optional build macro EMERG_EN adds the emerg input, which forces an all-red hold in S8.
module traffic_phase_sequencer #(
  parameter int unsigned T_GREEN  = 10,
  parameter int unsigned T_YELLOW = 3,
  parameter int unsigned T_ALLRED = 2,
  parameter int unsigned T_PED    = 8,
  parameter int unsigned CNT_W    = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tick,
  input  logic             ped_btn,
`ifdef EMERG_EN
  input  logic             emerg,
`endif
  output logic [2:0]       color,
  output logic [CNT_W-1:0] remain,
  output logic             ped_pending
);

  // Each state's encoding is also its exported colour code.
  typedef enum logic [2:0] {
    S1 = 3'b000,  // santa green
    S2 = 3'b001,  // santa yellow
    S3 = 3'b010,  // intersection green
    S4 = 3'b011,  // intersection yellow
    S5 = 3'b100,  // intersection + pedestrian green
    S6 = 3'b101,  // yellow after pedestrian phase
    S7 = 3'b110,  // all-red before S3
    S8 = 3'b111   // all-red before S1
  } state_e;

  localparam logic [CNT_W-1:0] LD_GREEN  = CNT_W'(T_GREEN - 1);
  localparam logic [CNT_W-1:0] LD_YELLOW = CNT_W'(T_YELLOW - 1);
  localparam logic [CNT_W-1:0] LD_ALLRED = CNT_W'(T_ALLRED - 1);
  localparam logic [CNT_W-1:0] LD_PED    = CNT_W'(T_PED - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] remain_q, remain_d;
  logic             ped_q, ped_d;

  // Counter load value for the phase being entered.
  function automatic logic [CNT_W-1:0] load_for(input state_e s);
    case (s)
      S1, S3:     load_for = LD_GREEN;
      S2, S4, S6: load_for = LD_YELLOW;
      S5:         load_for = LD_PED;
      S7, S8:     load_for = LD_ALLRED;
    endcase
  endfunction

  // State, counter and pedestrian latch registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S1;
      remain_q <= LD_GREEN;
      ped_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      remain_q <= remain_d;
      ped_q    <= ped_d;
    end
  end

  // Next-state: count down on tick, advance on expiry, latch/clear pedestrian requests.
  always_comb begin
    state_d  = state_q;
    remain_d = remain_q;
    ped_d    = ped_q;

    if (tick) begin
      if (remain_q == '0) begin
        case (state_q)
          S1: state_d = S2;
          S2: state_d = S7;
          S7: state_d = S3;
          S3: state_d = ped_q ? S5 : S4;
          S4: state_d = S8;
          S5: state_d = S6;
          S6: state_d = S8;
          S8: state_d = S1;
        endcase
        remain_d = load_for(state_d);
      end else begin
        remain_d = remain_q - CNT_W'(1);
      end
    end

`ifdef EMERG_EN
    // Emergency overrides timing entirely; the S8 counter restarts once emerg falls.
    if (emerg) begin
      state_d  = S8;
      remain_d = LD_ALLRED;
    end
`endif

    // Presses are ignored while the pedestrian phase is already running.
    if (ped_btn && (state_q != S5)) ped_d = 1'b1;
    // Entering S5 serves the request; this clear wins over a same-cycle press.
    if ((state_d == S5) && (state_q != S5)) ped_d = 1'b0;
  end

  assign color       = state_q;
  assign remain      = remain_q;
  assign ped_pending = ped_q;

endmodule
